// File: rtl/fetch_pc_ctrl.sv
// Instruction fetch sequencer: drives the fetch PC, hands instructions to ID,
// tracks branch delay slots, and redirects (with response drain) on flush.
module fetch_pc_ctrl #(
    parameter logic [31:0] PC_RESET_ADDR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_in_delay_slot,
    output logic        id_addr_err
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] fetch_addr_r;
    logic [31:0] drain_addr_r;
    logic        pend_r;
    logic [31:0] pend_target_r;
    logic        halt_r;
    logic [31:0] buf_pc_r;
    logic [31:0] buf_inst_r;
    logic        buf_err_r;
    logic        id_valid_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_inst_r;
    logic        id_ds_r;
    logic        id_err_r;

    logic        misalign_s;
    logic        req_s;
    logic        ack_s;
    logic        outstanding_s;
    logic        avail_s;
    logic [31:0] item_pc_s;
    logic [31:0] item_inst_s;
    logic        item_err_s;
    logic        handoff_s;
    logic        take_s;
    logic        capture_s;
    logic [31:0] next_pc_s;

    assign misalign_s    = (fetch_addr_r[1:0] != 2'b00);
    assign mem_req       = req_s & ~rst;
    assign ack_s         = mem_ack & mem_req;
    assign outstanding_s = mem_req & ~mem_ack;
    assign mem_addr      = (state_r == ST_DRAIN) ? drain_addr_r : fetch_addr_r;
    assign handoff_s     = avail_s & ~stall & ~flush;
    assign take_s        = branch_flag & id_valid_r & ~stall & ~flush;
    assign capture_s     = (state_r == ST_FETCH) & avail_s & stall & ~flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; flush only leaves DRAIN pending when a request is still in flight
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (flush) begin
                    state_next_s = outstanding_s ? ST_DRAIN : ST_FETCH;
                end else if (avail_s && stall) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (flush || !stall) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (ack_s) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // Per-state request and available-instruction selection; a misaligned PC acts as an immediate zero response
    always_comb begin
        req_s       = 1'b0;
        avail_s     = 1'b0;
        item_pc_s   = fetch_addr_r;
        item_inst_s = 32'h0000_0000;
        item_err_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                req_s       = ~halt_r & ~misalign_s;
                avail_s     = ~halt_r & (misalign_s | mem_ack);
                item_pc_s   = fetch_addr_r;
                item_inst_s = misalign_s ? 32'h0000_0000 : mem_rdata;
                item_err_s  = misalign_s;
            end
            ST_HOLD: begin
                req_s       = 1'b0;
                avail_s     = 1'b1;
                item_pc_s   = buf_pc_r;
                item_inst_s = buf_inst_r;
                item_err_s  = buf_err_r;
            end
            ST_DRAIN: begin
                req_s       = 1'b1;
                avail_s     = 1'b0;
            end
            default: begin
                req_s       = 1'b0;
                avail_s     = 1'b0;
            end
        endcase
    end

    // Address following a handoff: branch taken this cycle, then pending target, then sequential
    always_comb begin
        if (take_s) begin
            next_pc_s = branch_target_addr;
        end else if (pend_r) begin
            next_pc_s = pend_target_r;
        end else begin
            next_pc_s = item_pc_s + 32'd4;
        end
    end

    // Fetch address and the address held on the bus while draining
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr_r <= PC_RESET_ADDR;
            drain_addr_r <= 32'h0000_0000;
        end else begin
            if (flush) begin
                fetch_addr_r <= flush_pc;
            end else if (handoff_s) begin
                fetch_addr_r <= next_pc_s;
            end else begin
                fetch_addr_r <= fetch_addr_r;
            end
            if (flush && (state_r == ST_FETCH) && outstanding_s) begin
                drain_addr_r <= fetch_addr_r;
            end else begin
                drain_addr_r <= drain_addr_r;
            end
        end
    end

    // Pending branch target and the post-misalignment halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r        <= 1'b0;
            pend_target_r <= 32'h0000_0000;
            halt_r        <= 1'b0;
        end else if (flush) begin
            pend_r        <= 1'b0;
            pend_target_r <= pend_target_r;
            halt_r        <= 1'b0;
        end else if (handoff_s) begin
            pend_r        <= 1'b0;
            pend_target_r <= pend_target_r;
            halt_r        <= halt_r | item_err_s;
        end else if (take_s) begin
            pend_r        <= 1'b1;
            pend_target_r <= branch_target_addr;
            halt_r        <= halt_r;
        end else begin
            pend_r        <= pend_r;
            pend_target_r <= pend_target_r;
            halt_r        <= halt_r;
        end
    end

    // One-entry buffer for a response that arrived while ID was stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_pc_r   <= 32'h0000_0000;
            buf_inst_r <= 32'h0000_0000;
            buf_err_r  <= 1'b0;
        end else if (flush) begin
            buf_pc_r   <= 32'h0000_0000;
            buf_inst_r <= 32'h0000_0000;
            buf_err_r  <= 1'b0;
        end else if (capture_s) begin
            buf_pc_r   <= item_pc_s;
            buf_inst_r <= item_inst_s;
            buf_err_r  <= item_err_s;
        end else begin
            buf_pc_r   <= buf_pc_r;
            buf_inst_r <= buf_inst_r;
            buf_err_r  <= buf_err_r;
        end
    end

    // ID stage registers: load on handoff, bubble when ID is free but nothing arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_r <= 1'b0;
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= 32'h0000_0000;
            id_ds_r    <= 1'b0;
            id_err_r   <= 1'b0;
        end else if (flush) begin
            id_valid_r <= 1'b0;
        end else if (handoff_s) begin
            id_valid_r <= 1'b1;
            id_pc_r    <= item_pc_s;
            id_inst_r  <= item_inst_s;
            id_ds_r    <= pend_r | take_s;
            id_err_r   <= item_err_s;
        end else if (!stall) begin
            id_valid_r <= 1'b0;
        end else begin
            id_valid_r <= id_valid_r;
        end
    end

    assign id_valid         = id_valid_r;
    assign id_pc            = id_pc_r;
    assign id_inst          = id_inst_r;
    assign id_in_delay_slot = id_ds_r;
    assign id_addr_err      = id_err_r;

endmodule
